// File: rtl/multicycle_control.sv
// Multicycle sequencer for the RV64 datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, waits on
// instruction/data memory ready handshakes, drives the datapath strobes and
// counts retired instructions. Illegal opcodes park the sequencer in TRAP.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             Clk,
    input  logic             En,
    input  logic             start,
    input  logic             halt,
    input  logic [6:0]       instr,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_read,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             busy,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_r, is_i, is_load, is_store, is_branch, is_legal;
    logic retire;

    // Opcode class decode from the latched opcode register
    always_comb begin
        is_r      = (opcode_q == OP_R);
        is_i      = (opcode_q == OP_I);
        is_load   = (opcode_q == OP_LOAD);
        is_store  = (opcode_q == OP_STORE);
        is_branch = (opcode_q == OP_BRANCH);
        is_legal  = is_r | is_i | is_load | is_store | is_branch;
    end

    // Next-state, retire detection and strobe generation; all strobes forced low while En is high
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        cnt_d      = cnt_q;
        retire     = 1'b0;
        imem_read  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;

        if (!En) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_FETCH;
                end
                S_FETCH: begin
                    imem_read = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        opcode_d = instr;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_d = is_legal ? S_EXECUTE : S_TRAP;
                end
                S_EXECUTE: begin
                    if (is_r) begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end else if (is_i) begin
                        alu_src = 1'b1;
                        alu_op  = 2'b11;
                        state_d = S_WB;
                    end else if (is_load || is_store) begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end else begin
                        // Only BRANCH can reach here; it retires in EXECUTE
                        alu_op   = 2'b01;
                        pc_write = 1'b1;
                        pc_src   = alu_zero;
                        retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    alu_src   = 1'b1;
                    mem_read  = is_load;
                    mem_write = is_store;
                    if (dmem_ready) begin
                        if (is_load) begin
                            state_d = S_WB;
                        end else begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_load;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: state_d = S_IDLE;
            endcase

            if (retire) begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = halt ? S_IDLE : S_FETCH;
            end
        end
    end

    // State, opcode and retire-counter registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (En) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    // Status outputs, held low during the reset cycle
    always_comb begin
        busy        = !En && (state_q != S_IDLE) && (state_q != S_TRAP);
        trap        = !En && (state_q == S_TRAP);
        instr_count = En ? '0 : cnt_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control with a 4-bit counter.
module tb_multicycle_control;

    logic       Clk;
    logic       En, start, halt, alu_zero, imem_ready, dmem_ready;
    logic [6:0] instr;
    logic       imem_read, ir_write, pc_write, pc_src, reg_write;
    logic       mem_read, mem_write, mem_to_reg, alu_src, busy, trap;
    logic [1:0] alu_op;
    logic [3:0] instr_count;
    logic [12:0] obs;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.CNT_W(4)) dut (
        .Clk(Clk), .En(En), .start(start), .halt(halt), .instr(instr),
        .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_read(imem_read), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .alu_op(alu_op), .busy(busy), .trap(trap), .instr_count(instr_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {imem_read, ir_write, pc_write, pc_src, reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op, busy, trap}
    assign obs = {imem_read, ir_write, pc_write, pc_src, reg_write, mem_read,
                  mem_write, mem_to_reg, alu_src, alu_op, busy, trap};

    localparam logic [12:0] Z      = 13'b0_0_0_0_0_0_0_0_0_00_0_0;
    localparam logic [12:0] F_WAIT = 13'b1_0_0_0_0_0_0_0_0_00_1_0;
    localparam logic [12:0] F_RDY  = 13'b1_1_0_0_0_0_0_0_0_00_1_0;
    localparam logic [12:0] DEC    = 13'b0_0_0_0_0_0_0_0_0_00_1_0;
    localparam logic [12:0] EX_R   = 13'b0_0_0_0_0_0_0_0_0_10_1_0;
    localparam logic [12:0] EX_I   = 13'b0_0_0_0_0_0_0_0_1_11_1_0;
    localparam logic [12:0] EX_LS  = 13'b0_0_0_0_0_0_0_0_1_00_1_0;
    localparam logic [12:0] EX_BZ  = 13'b0_0_1_1_0_0_0_0_0_01_1_0;
    localparam logic [12:0] EX_BN  = 13'b0_0_1_0_0_0_0_0_0_01_1_0;
    localparam logic [12:0] MEM_LD = 13'b0_0_0_0_0_1_0_0_1_00_1_0;
    localparam logic [12:0] MEM_ST = 13'b0_0_1_0_0_0_1_0_1_00_1_0;
    localparam logic [12:0] WB_R   = 13'b0_0_1_0_1_0_0_0_0_00_1_0;
    localparam logic [12:0] WB_LD  = 13'b0_0_1_0_1_0_0_1_0_00_1_0;
    localparam logic [12:0] TRAPV  = 13'b0_0_0_0_0_0_0_0_0_00_0_1;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] ev, input logic [3:0] ec);
        #1;
        checks++;
        assert (obs === ev) else begin
            failures++;
            $error("FAIL %s strobes observed=%b expected=%b", tag, obs, ev);
        end
        checks++;
        assert (instr_count === ec) else begin
            failures++;
            $error("FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, ec);
        end
    endtask

    initial begin
        En = 1'b1; start = 1'b0; halt = 1'b0; alu_zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; instr = '0;
        step();
        chk("reset", Z, 4'd0);

        // R-type, both ready inputs high
        En = 1'b0; start = 1'b1; instr = OP_R; imem_ready = 1'b1; dmem_ready = 1'b1;
        chk("idle_start", Z, 4'd0);
        step(); start = 1'b0;
        chk("r_fetch", F_RDY, 4'd0); step();
        chk("r_decode", DEC, 4'd0); step();
        chk("r_exec", EX_R, 4'd0); step();
        chk("r_wb", WB_R, 4'd0); step();

        // I-ALU
        instr = OP_I;
        chk("i_fetch", F_RDY, 4'd1); step();
        chk("i_decode", DEC, 4'd1); step();
        chk("i_exec", EX_I, 4'd1); step();
        chk("i_wb", WB_R, 4'd1); step();

        // LOAD with one imem wait and three dmem waits
        instr = OP_LD; imem_ready = 1'b0;
        chk("ld_fetch_wait", F_WAIT, 4'd2); step();
        imem_ready = 1'b1;
        chk("ld_fetch", F_RDY, 4'd2); step();
        chk("ld_decode", DEC, 4'd2); step();
        chk("ld_exec", EX_LS, 4'd2); step();
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ld_mem_wait", MEM_LD, 4'd2); step();
        end
        dmem_ready = 1'b1;
        chk("ld_mem_done", MEM_LD, 4'd2); step();
        chk("ld_wb", WB_LD, 4'd2); step();

        // BRANCH taken then not taken
        instr = OP_BR; alu_zero = 1'b1;
        chk("bz_fetch", F_RDY, 4'd3); step();
        chk("bz_decode", DEC, 4'd3); step();
        chk("bz_exec", EX_BZ, 4'd3); step();
        alu_zero = 1'b0;
        chk("bn_fetch", F_RDY, 4'd4); step();
        chk("bn_decode", DEC, 4'd4); step();
        chk("bn_exec", EX_BN, 4'd4); step();

        // STORE retiring with halt
        instr = OP_ST;
        chk("st_fetch", F_RDY, 4'd5); step();
        chk("st_decode", DEC, 4'd5); step();
        chk("st_exec", EX_LS, 4'd5); step();
        halt = 1'b1;
        chk("st_mem", MEM_ST, 4'd5); step();
        halt = 1'b0;
        chk("halt_idle", Z, 4'd6); step();
        chk("halt_idle_hold", Z, 4'd6);
        start = 1'b1;
        chk("halt_idle_start", Z, 4'd6); step();
        start = 1'b0; instr = OP_BAD;

        // Illegal opcode
        chk("bad_fetch", F_RDY, 4'd6); step();
        chk("bad_decode", DEC, 4'd6); step();
        chk("trap_enter", TRAPV, 4'd6);
        start = 1'b1; step();
        chk("trap_start1", TRAPV, 4'd6);
        start = 1'b0; step();
        chk("trap_start0", TRAPV, 4'd6);
        En = 1'b1;
        chk("trap_reset", Z, 4'd0); step();
        En = 1'b0;
        chk("trap_cleared", Z, 4'd0);

        // 16 branches wrap the 4-bit counter
        start = 1'b1; step();
        start = 1'b0; instr = OP_BR; alu_zero = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("wrap_fetch", F_RDY, 4'(i)); step();
            step();
            chk("wrap_exec", EX_BN, 4'(i)); step();
        end
        chk("wrap_zero", F_RDY, 4'd0); step();
        step();
        chk("pre_exec", EX_BN, 4'd0); step();

        // Reset mid-MEM
        instr = OP_LD;
        chk("mr_fetch", F_RDY, 4'd1); step();
        step();
        step();
        dmem_ready = 1'b0;
        chk("mr_mem", MEM_LD, 4'd1); step();
        chk("mr_mem2", MEM_LD, 4'd1);
        En = 1'b1;
        chk("mr_reset", Z, 4'd0); step();
        En = 1'b0;
        chk("mr_idle", Z, 4'd0); step();
        chk("mr_idle_hold", Z, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the RV64 datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states and waits on ready handshakes from the instruction and data memories. It drives the datapath strobes now produced by the single-cycle control and ALU-control path: PC write, IR write, register write, memory read/write, mux selects and ALU op. It sits between the top-level datapath and the memories and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `Clk` input 1: system clock. All state changes on the rising edge.
- `En` input 1: synchronous, active-high reset. Sampled on the `Clk` rising edge.
- `start` input 1: leave IDLE and begin fetching.
- `halt` input 1: sampled at retire. When 1, return to IDLE instead of FETCH.
- `instr` input 7: opcode field (instruction[6:0]) from the instruction memory output.
- `alu_zero` input 1: ALU zero flag.
- `imem_ready` input 1: instruction memory data valid this cycle.
- `dmem_ready` input 1: data memory access complete this cycle.
- `imem_read` output 1: instruction fetch request.
- `ir_write` output 1: latch the instruction register.
- `pc_write` output 1: update the PC.
- `pc_src` output 1: 0 selects PC+4, 1 selects the branch target.
- `reg_write` output 1: register file write enable.
- `mem_read`, `mem_write` output 1 each: data memory strobes.
- `mem_to_reg` output 1: 1 selects memory data for register writeback.
- `alu_src` output 1: 1 selects the immediate.
- `alu_op` output 2: 00 add, 01 branch compare, 10 R-type functional, 11 I-type functional.
- `busy` output 1: 1 in any state other than IDLE and TRAP.
- `trap` output 1: sticky illegal-opcode flag.
- `instr_count` output CNT_W: number of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. The encoding is free.
- Reset (`En`=1): next state IDLE, `instr_count`=0, `trap`=0, opcode register=0. Reset overrides every other event, including mid-instruction and TRAP.
- Every output is 0 in IDLE and during the reset cycle. `busy`=0 in IDLE.
- IDLE: go to FETCH when `start`=1. Otherwise stay.
- FETCH: `imem_read`=1. Wait while `imem_ready`=0. When `imem_ready`=1, `ir_write`=1 in that same cycle, the opcode register captures `instr`, and the next state is DECODE.
- DECODE: one cycle. Classify the opcode register:
  - 0110011 R
  - 0010011 I-ALU
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - Any other opcode goes to TRAP. Otherwise go to EXECUTE.
- EXECUTE: one cycle. Drives `alu_src` and `alu_op`:
  - R: `alu_src`=0, `alu_op`=10; go to WRITEBACK.
  - I-ALU: `alu_src`=1, `alu_op`=11; go to WRITEBACK.
  - LOAD and STORE: `alu_src`=1, `alu_op`=00; go to MEM.
  - BRANCH: `alu_src`=0, `alu_op`=01, `pc_write`=1, `pc_src`=`alu_zero`. The instruction retires here.
- MEM: holds `alu_src`=1 and `alu_op`=00.
  - LOAD: `mem_read`=1.
  - STORE: `mem_write`=1.
  - Stay while `dmem_ready`=0.
  - On `dmem_ready`=1, LOAD goes to WRITEBACK and STORE retires in that cycle with `pc_write`=1, `pc_src`=0.
- WRITEBACK: one cycle. `reg_write`=1, `mem_to_reg`=1 for LOAD and 0 otherwise, `pc_write`=1, `pc_src`=0. The instruction retires.
- Retire cycle:
  - `instr_count` increments by 1. It wraps from all-ones to 0 with no flag.
  - Next state is IDLE if `halt`=1, else FETCH.
  - `halt` has no effect outside the retire cycle.
- TRAP: `trap`=1 and all strobes are 0. Stay until reset. `instr_count` is not incremented.
- `ir_write`, `pc_write`, `pc_src` and the FETCH/MEM exits depend combinationally on the ready and zero inputs (Mealy). All other outputs decode from the state and opcode registers.
- Exactly one `pc_write` pulse per retired instruction. No `pc_write` or `reg_write` for a trapping instruction.

## Timing
Minimum cycles per instruction with the ready input high on first request:
- R and I-ALU: 4 (FETCH, DECODE, EXECUTE, WRITEBACK).
- LOAD: 5.
- STORE: 4.
- BRANCH: 3.

Other timing rules:
- Each cycle of `imem_ready`=0 or `dmem_ready`=0 adds exactly one cycle.
- A ready input asserted in any state other than its own wait state is ignored.
- `start` to first `imem_read`: 1 cycle.
- `En` deassertion to first possible FETCH: 1 cycle, provided `start`=1.

## Test plan
- Reset, `start`=1 with R opcode 0110011 and both ready inputs held 1: states FETCH, DECODE, EXECUTE, WB. `reg_write`=1 on cycle 4 only, one `pc_write`, `instr_count`=1 after retire.
- LOAD 0000011 with `dmem_ready` low for 3 cycles: MEM lasts 4 cycles with `mem_read`=1. Then WB with `mem_to_reg`=1 and `reg_write`=1. Total 8 cycles.
- BRANCH 1100011, once with `alu_zero`=1 and once with `alu_zero`=0: in EXECUTE, `pc_write`=1 with `pc_src`=1 and `pc_src`=0 respectively. No `reg_write`. 3 cycles each.
- Opcode 1111111: DECODE goes to TRAP. `trap`=1 stays set while `start` toggles, `busy`=0, no strobes. Asserting `En` clears `trap` and returns to IDLE.
- `halt`=1 at a STORE retire: `mem_write`=1 for one cycle, then IDLE. `imem_read` stays 0 until `start` is asserted.
- `En` asserted mid-MEM with `dmem_ready`=0, and `instr_count` preset near wrap (retire 2^CNT_W instructions or use a small CNT_W=4): after reset all outputs are 0 and the state is IDLE. With CNT_W=4, 16 retires return `instr_count` to 0.
